mips_mem_arbiter: RTL

- Single-port memory arbiter for the 5-stage MIPS_32 pipeline.
- Shares one synchronous instruction/data RAM between two requesters: the IF stage (instruction fetch) and the MEM stage (LW/SW).
- Non-pipelined: exactly one access in flight at a time. Fixed data-over-fetch priority, with an anti-starvation override and branch-flush and halt controls.

---
 rtl/mips_mem_pkg.sv | 11 +
 rtl/mips_mem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the MIPS_32 single-port memory arbiter.
package mips_mem_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;

  typedef enum logic [1:0] {NONE = 2'd0, FETCH = 2'd1, DATA = 2'd2} owner_t;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Single-port RAM arbiter between IF (fetch) and MEM (load/store) stages.
// One access in flight; data beats fetch unless fetch has lost MAX_WAIT times in a row.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              if_flush,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  input  logic              halt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LAT_INIT   = 3'(RAM_LAT - 1);
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t            state_r, state_s;
  owner_t            owner_r, owner_s;
  logic [3:0]        wait_cnt_r, wait_cnt_s;
  logic [2:0]        lat_cnt_r, lat_cnt_s;
  logic              flushed_r, flushed_s;
  logic              if_gnt_s, dm_gnt_s, if_rvalid_s, dm_rvalid_s;
  logic              mem_en_s, mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s, if_rdata_s, dm_rdata_s;

  // Next-state, arbitration and next-output logic.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    wait_cnt_s  = wait_cnt_r;
    lat_cnt_s   = lat_cnt_r;
    flushed_s   = flushed_r;
    if_gnt_s    = 1'b0;
    dm_gnt_s    = 1'b0;
    if_rvalid_s = 1'b0;
    dm_rvalid_s = 1'b0;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    if_rdata_s  = if_rdata;
    dm_rdata_s  = dm_rdata;

    case (state_r)
      IDLE: begin
        if (halt) begin
          state_s = IDLE;
        end else if ((if_req && (wait_cnt_r == MAX_WAIT_C)) || (if_req && !dm_req)) begin
          state_s    = ACCESS;
          owner_s    = FETCH;
          if_gnt_s   = 1'b1;
          mem_en_s   = 1'b1;
          mem_addr_s = if_addr;
          wait_cnt_s = 4'd0;
          flushed_s  = 1'b0;
        end else if (dm_req) begin
          state_s     = ACCESS;
          owner_s     = DATA;
          dm_gnt_s    = 1'b1;
          mem_en_s    = 1'b1;
          mem_we_s    = dm_we;
          mem_addr_s  = dm_addr;
          mem_wdata_s = dm_wdata;
          flushed_s   = 1'b0;
          // A fetch that lost this arbitration moves closer to its forced win.
          if (if_req && (wait_cnt_r < MAX_WAIT_C)) begin
            wait_cnt_s = wait_cnt_r + 4'd1;
          end else begin
            wait_cnt_s = wait_cnt_r;
          end
        end else begin
          state_s = IDLE;
        end
      end

      ACCESS: begin
        flushed_s = flushed_r | ((owner_r == FETCH) & if_flush);
        if ((owner_r == DATA) && mem_we) begin
          state_s = IDLE;
          owner_s = NONE;
        end else begin
          state_s   = WAIT;
          lat_cnt_s = LAT_INIT;
        end
      end

      WAIT: begin
        flushed_s = flushed_r | ((owner_r == FETCH) & if_flush);
        if (lat_cnt_r == 3'd0) begin
          state_s = IDLE;
          owner_s = NONE;
          if (owner_r == FETCH) begin
            if (!(flushed_r || if_flush)) begin
              if_rvalid_s = 1'b1;
              if_rdata_s  = mem_rdata;
            end else begin
              if_rvalid_s = 1'b0;
            end
          end else if (owner_r == DATA) begin
            dm_rvalid_s = 1'b1;
            dm_rdata_s  = mem_rdata;
          end else begin
            dm_rvalid_s = 1'b0;
          end
        end else begin
          lat_cnt_s = lat_cnt_r - 3'd1;
        end
      end

      default: begin
        state_s = IDLE;
        owner_s = NONE;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      owner_r    <= NONE;
      wait_cnt_r <= 4'd0;
      lat_cnt_r  <= 3'd0;
      flushed_r  <= 1'b0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
      if_rdata   <= {DATA_W{1'b0}};
      dm_rdata   <= {DATA_W{1'b0}};
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      wait_cnt_r <= wait_cnt_s;
      lat_cnt_r  <= lat_cnt_s;
      flushed_r  <= flushed_s;
      if_gnt     <= if_gnt_s;
      dm_gnt     <= dm_gnt_s;
      if_rvalid  <= if_rvalid_s;
      dm_rvalid  <= dm_rvalid_s;
      mem_en     <= mem_en_s;
      mem_we     <= mem_we_s;
      mem_addr   <= mem_addr_s;
      mem_wdata  <= mem_wdata_s;
      if_rdata   <= if_rdata_s;
      dm_rdata   <= dm_rdata_s;
      busy       <= (state_s != IDLE);
    end
  end

endmodule
